// File: rtl/id_issue_queue_if.sv
// Enqueue (fetch side) and issue (EX side) handshake bundle for id_issue_queue.
// The slave modport is the queue itself; the master modport is its environment.
interface id_issue_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic            in_r_rs1;
  logic            in_r_rs2;
  logic            in_w_rd;
  logic            in_long;
  logic            in_op1_pc;
  logic            in_op2_imm;
  logic [XLEN-1:0] in_imm;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [4:0]      out_rd;
  logic            out_w_rd;
  logic            out_long;

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_r_rs1, in_r_rs2,
           in_w_rd, in_long, in_op1_pc, in_op2_imm, in_imm, out_ready,
    output in_ready, out_valid, out_pc, out_op1, out_op2, out_rd, out_w_rd, out_long
  );

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_r_rs1, in_r_rs2,
           in_w_rd, in_long, in_op1_pc, in_op2_imm, in_imm, out_ready,
    input  in_ready, out_valid, out_pc, out_op1, out_op2, out_rd, out_w_rd, out_long
  );
endinterface

// File: rtl/id_issue_queue.sv
// br32 decode/issue stage: DEPTH-entry instruction queue, operand read with
// NFWD-source forwarding, late-result hazard stalls and a registered ID/EX output.
module id_issue_queue #(
  parameter int DEPTH = 4,
  parameter int NFWD  = 3,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  id_issue_queue_if.slave            io,
  output logic [4:0]                 rf_raddr1,
  output logic [4:0]                 rf_raddr2,
  input  logic [XLEN-1:0]            rf_rdata1,
  input  logic [XLEN-1:0]            rf_rdata2,
  input  logic [NFWD-1:0]            fwd_valid,
  input  logic [NFWD-1:0]            fwd_late,
  input  logic [5*NFWD-1:0]          fwd_rd,
  input  logic [XLEN*NFWD-1:0]       fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [15:0]                stall_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            r_rs1;
    logic            r_rs2;
    logic            w_rd;
    logic            is_long;
    logic            op1_pc;
    logic            op2_imm;
    logic [XLEN-1:0] imm;
  } entry_t;

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic            late;
  } opnd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lowest-index matching source wins, so scan from oldest to youngest and overwrite.
  function automatic opnd_t sel_operand(
    input logic [4:0]           rs,
    input logic [XLEN-1:0]      rdata,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD-1:0]      fl,
    input logic [5*NFWD-1:0]    frd,
    input logic [XLEN*NFWD-1:0] fdat
  );
    opnd_t r;
    r.val  = rdata;
    r.late = 1'b0;
    if (rs == 5'd0) begin
      r.val = '0;
    end else begin
      for (int i = NFWD-1; i >= 0; i--) begin
        if (fv[i] && (frd[5*i +: 5] == rs)) begin
          r.val  = fdat[XLEN*i +: XLEN];
          r.late = fl[i];
        end
      end
    end
    return r;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          head;
  entry_t          wr_entry;
  opnd_t           src1;
  opnd_t           src2;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     stall_q, stall_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_op1_q, out_op1_d;
  logic [XLEN-1:0] out_op2_q, out_op2_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_w_rd_q, out_w_rd_d;
  logic            out_long_q, out_long_d;

  logic            head_vld, hazard, issue, enq;
  logic [XLEN-1:0] op1_val, op2_val;

  always_comb begin
    wr_entry.pc      = io.in_pc;
    wr_entry.rs1     = io.in_rs1;
    wr_entry.rs2     = io.in_rs2;
    wr_entry.rd      = io.in_rd;
    wr_entry.r_rs1   = io.in_r_rs1;
    wr_entry.r_rs2   = io.in_r_rs2;
    wr_entry.w_rd    = io.in_w_rd;
    wr_entry.is_long = io.in_long;
    wr_entry.op1_pc  = io.in_op1_pc;
    wr_entry.op2_imm = io.in_op2_imm;
    wr_entry.imm     = io.in_imm;
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_vld  = (count_q != '0);
  assign io.in_ready = (count_q != CW'(DEPTH));
  assign enq       = io.in_valid && io.in_ready;
  assign rf_raddr1 = head.rs1;
  assign rf_raddr2 = head.rs2;

  // Operand read and hazard detection on the head entry.
  always_comb begin
    src1    = sel_operand(head.rs1, rf_rdata1, fwd_valid, fwd_late, fwd_rd, fwd_data);
    src2    = sel_operand(head.rs2, rf_rdata2, fwd_valid, fwd_late, fwd_rd, fwd_data);
    op1_val = head.op1_pc  ? head.pc  : src1.val;
    op2_val = head.op2_imm ? head.imm : src2.val;
    hazard  = (!head.op1_pc  && head.r_rs1 && src1.late) ||
              (!head.op2_imm && head.r_rs2 && src2.late);
    issue   = head_vld && !hazard && (!out_valid_q || io.out_ready);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_d     = (head_vld && hazard) ? sat_inc16(stall_q) : stall_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    out_w_rd_d  = out_w_rd_q;
    out_long_d  = out_long_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (enq)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !issue)      count_d = count_q + 1'b1;
      else if (!enq && issue) count_d = count_q - 1'b1;

      if (issue) begin
        out_valid_d = 1'b1;
        out_pc_d    = head.pc;
        out_op1_d   = op1_val;
        out_op2_d   = op2_val;
        out_rd_d    = head.rd;
        out_w_rd_d  = head.w_rd;
        out_long_d  = head.is_long;
      end else if (io.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Queue storage carries no reset; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_w_rd_q  <= 1'b0;
      out_long_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      out_w_rd_q  <= out_w_rd_d;
      out_long_q  <= out_long_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_pc    = out_pc_q;
  assign io.out_op1   = out_op1_q;
  assign io.out_op2   = out_op2_q;
  assign io.out_rd    = out_rd_q;
  assign io.out_w_rd  = out_w_rd_q;
  assign io.out_long  = out_long_q;
  assign occupancy    = count_q;
  assign stall_cycles = stall_q;

endmodule
